// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the MDR/MAR memory interface.
package mem_if_pkg;

    localparam int ADDR_W_DEF      = 9;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for the access phase; expired is high in the LIMIT-th enabled cycle.
// Latency: combinational flag off a registered count; no backpressure, holds at the limit.
module mem_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr || clear) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mdr_mar_mem_if.sv
// MAR/MDR registers and a single-outstanding memory request handshake with timeout.
// Latency: request the cycle after start, done the cycle after ack; starts while busy are dropped.
module mdr_mar_mem_if
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic [31:0]       mdr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         mdr_q;
    logic                we_q;
    logic                err_q;
    logic                tmo_expired;

    logic is_idle, is_access, start, illegal, acked;

    assign is_idle   = (state_q == ST_IDLE);
    assign is_access = (state_q == ST_ACCESS);
    assign start     = is_idle && (mem_rd ^ mem_wr);
    assign illegal   = is_idle && mem_rd && mem_wr;
    assign acked     = is_access && mem_ack;

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .clr     (clr),
        .clear   (!is_access),
        .en      (is_access),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (mem_ack)          state_d = ST_DONE;
                else if (tmo_expired) state_d = ST_IDLE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // addr_q snapshots the pre-edge MAR so a same-edge MARin cannot retarget the access.
    always_ff @(posedge clk) begin
        if (clr) begin
            mar_q  <= '0;
            mdr_q  <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (is_idle && MARin) begin
                mar_q <= bus_in[ADDR_W-1:0];
            end
            if (acked && !we_q) begin
                mdr_q <= mem_rdata;
            end else if (is_idle && MDRin) begin
                mdr_q <= bus_in;
            end
            if (start) begin
                addr_q <= mar_q;
                we_q   <= mem_wr;
            end
            err_q <= illegal || (is_access && !mem_ack && tmo_expired);
        end
    end

    always_comb begin
        mem_req   = is_access;
        mem_we    = is_access && we_q;
        busy      = !is_idle;
        done      = (state_q == ST_DONE);
        err       = err_q;
        mdr_out   = mdr_q;
        mem_wdata = mdr_q;
        mem_addr  = is_idle ? mar_q : addr_q;
    end

endmodule

// File: tb/tb_mdr_mar_mem_if.sv
// Bench for mdr_mar_mem_if: vector table of transactions with a completion scoreboard,
// plus hand sequences for illegal start, busy loads, same-edge loads and clear mid-access.
module tb_mdr_mar_mem_if;

    logic        clk;
    logic        clr;
    logic [31:0] bus_in;
    logic        MARin, MDRin, mem_rd, mem_wr;
    logic [31:0] mdr_out;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy, done, err;

    mdr_mar_mem_if #(.ADDR_W(9), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus_in    (bus_in),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mdr_out   (mdr_out),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] rdata;
        logic        exp_done;
        logic [31:0] exp_mdr;
        int          exp_steps;
    } txn_t;

    typedef struct {
        logic        done;
        logic        err;
        logic [31:0] mdr;
        int          steps;
    } sb_t;

    txn_t vec [6];
    sb_t  sbq [$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic run_txn(input int idx, input txn_t t);
        sb_t e;
        bit  seen;
        int  steps_seen;
        logic [8:0] exp_addr;
        exp_addr = t.addr[8:0];
        MARin = 1'b1; bus_in = t.addr;  step(); MARin = 1'b0;
        MDRin = 1'b1; bus_in = t.wdata; step(); MDRin = 1'b0;
        if (t.wr) mem_wr = 1'b1; else mem_rd = 1'b1;
        step();
        mem_wr = 1'b0; mem_rd = 1'b0;
        sbq.push_back('{t.exp_done, !t.exp_done, t.exp_mdr, t.exp_steps});
        chk($sformatf("v%0d_req", idx),   {31'd0, mem_req}, 32'd1);
        chk($sformatf("v%0d_we", idx),    {31'd0, mem_we}, {31'd0, t.wr});
        chk($sformatf("v%0d_addr", idx),  {23'd0, mem_addr}, {23'd0, exp_addr});
        chk($sformatf("v%0d_wdata", idx), mem_wdata, t.wdata);
        seen = 1'b0;
        steps_seen = 0;
        for (int n = 1; n <= 40; n++) begin
            mem_ack   = (t.ack_dly >= 0) && (n == t.ack_dly + 1);
            mem_rdata = t.rdata;
            step();
            mem_ack = 1'b0;
            if (done || err) begin
                seen = 1'b1;
                steps_seen = n;
                break;
            end
        end
        if (!seen) begin
            chk($sformatf("v%0d_complete_bound", idx), 32'd0, 32'd1);
        end else if (sbq.size() == 0) begin
            chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d_done", idx),  {31'd0, done}, {31'd0, e.done});
            chk($sformatf("v%0d_err", idx),   {31'd0, err}, {31'd0, e.err});
            chk($sformatf("v%0d_mdr", idx),   mdr_out, e.mdr);
            chk($sformatf("v%0d_steps", idx), steps_seen, e.steps);
            chk($sformatf("v%0d_req_drop", idx), {31'd0, mem_req}, 32'd0);
        end
        step();
        chk($sformatf("v%0d_pulse_end", idx), {30'd0, done, err}, 32'd0);
        chk($sformatf("v%0d_idle", idx), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec[0] = '{1'b0, 32'h0000_0123, 32'h1111_2222, 3,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 4};
        vec[1] = '{1'b1, 32'h0000_01FF, 32'h1234_5678, 0,  32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1};
        vec[2] = '{1'b0, 32'h0000_0010, 32'hAAAA_5555, -1, 32'h0BAD_0BAD, 1'b0, 32'hAAAA_5555, 16};
        vec[3] = '{1'b1, 32'h0000_03C0, 32'hCAFE_F00D, 15, 32'h0000_0000, 1'b1, 32'hCAFE_F00D, 16};
        vec[4] = '{1'b0, 32'hFFFF_F0AA, 32'h0101_0101, 5,  32'h0BAD_C0DE, 1'b1, 32'h0BAD_C0DE, 6};
        vec[5] = '{1'b1, 32'h0000_0055, 32'h55AA_55AA, -1, 32'h1357_9BDF, 1'b0, 32'h55AA_55AA, 16};

        clr = 1'b1; bus_in = '0; MARin = 0; MDRin = 0; mem_rd = 0; mem_wr = 0;
        mem_rdata = '0; mem_ack = 0;
        step(); step();
        clr = 1'b0;
        chk("rst_mdr",  mdr_out, 32'd0);
        chk("rst_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_ctl",  {26'd0, mem_req, mem_we, busy, done, err, 1'b0}, 32'd0);

        for (int i = 0; i < 6; i++) run_txn(i, vec[i]);

        // Illegal start: no request, err next cycle, MAR still loads.
        MARin = 1'b1; bus_in = 32'h0000_0077; mem_rd = 1'b1; mem_wr = 1'b1;
        step();
        MARin = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        chk("ill_req",  {31'd0, mem_req}, 32'd0);
        chk("ill_err",  {31'd0, err}, 32'd1);
        chk("ill_busy", {31'd0, busy}, 32'd0);
        step();
        chk("ill_err_end", {31'd0, err}, 32'd0);
        chk("ill_mar",     {23'd0, mem_addr}, 32'h077);

        // Same-edge MARin and start uses old MAR; MARin while busy ignored.
        MARin = 1'b1; bus_in = 32'h0000_00FF; mem_rd = 1'b1;
        step();
        mem_rd = 1'b0; bus_in = 32'h0000_01F0;
        chk("same_addr", {23'd0, mem_addr}, 32'h077);
        step();
        MARin = 1'b0;
        chk("busy_addr", {23'd0, mem_addr}, 32'h077);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
        step();
        mem_ack = 1'b0;
        chk("same_done", {31'd0, done}, 32'd1);
        step();
        chk("same_mar_loaded", {23'd0, mem_addr}, 32'h0FF);

        // MDRin with mem_rd: MDR takes bus, then read data on ack.
        MDRin = 1'b1; bus_in = 32'h0000_0099; mem_rd = 1'b1;
        step();
        MDRin = 1'b0; mem_rd = 1'b0;
        chk("mdrrd_load", mdr_out, 32'h0000_0099);
        mem_ack = 1'b1; mem_rdata = 32'h0000_4242;
        step();
        mem_ack = 1'b0;
        chk("mdrrd_ack", mdr_out, 32'h0000_4242);
        chk("mdrrd_done", {31'd0, done}, 32'd1);
        step();

        // Clear mid-access: no done/err, later ack ignored.
        MDRin = 1'b1; bus_in = 32'h0000_ABCD; step(); MDRin = 1'b0;
        mem_rd = 1'b1; step(); mem_rd = 1'b0;
        step();
        chk("clr_pre_req", {31'd0, mem_req}, 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_req", {31'd0, mem_req}, 32'd0);
        chk("clr_mdr", mdr_out, 32'd0);
        chk("clr_flags", {30'd0, done, err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_FFFF;
        step();
        mem_ack = 1'b0;
        chk("late_ack_mdr",  mdr_out, 32'd0);
        chk("late_ack_ctl",  {29'd0, busy, done, err}, 32'd0);
        step();
        chk("late_ack_done", {30'd0, done, err}, 32'd0);

        chk("sb_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
